// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state encoding, opcodes, selector codes and control word of the RV32I control FSM.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_JAL      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       pc_update;
      logic       branch;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: opcode/flag inputs and control outputs between the control FSM and the datapath.
interface multicycle_control_fsm_if #(parameter int STATE_WIDTH = 4);
   logic [6:0]             op;
   logic                   zero;
   logic                   pc_write;
   logic                   adr_src;
   logic                   mem_write;
   logic                   ir_write;
   logic                   reg_write;
   logic                   illegal_op;
   logic [1:0]             result_src;
   logic [1:0]             alu_src_a;
   logic [1:0]             alu_src_b;
   logic [1:0]             alu_op;
   logic [STATE_WIDTH-1:0] state_dbg;

   modport master (
      input  op, zero,
      output pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
             result_src, alu_src_a, alu_src_b, alu_op, state_dbg
   );

   modport slave (
      output op, zero,
      input  pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
             result_src, alu_src_a, alu_src_b, alu_op, state_dbg
   );
endinterface

// File: rtl/multicycle_control_fsm_control_output_decoder.sv
// control_output_decoder: Moore control word for each FSM state; unused encodings yield an all-zero word.
module control_output_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.ir_write   = 1'b1;
            ctrl_o.pc_update  = 1'b1;
            ctrl_o.alu_src_a  = SRCA_PC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            ctrl_o.alu_src_a = SRCA_OLDPC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.result_src = RES_MEMDATA;
         end
         S_MEMWRITE: begin
            ctrl_o.adr_src    = 1'b1;
            ctrl_o.mem_write  = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_EXECR: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_REG;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ctrl_o.alu_src_a = SRCA_REG;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_JAL: begin
            ctrl_o.pc_update  = 1'b1;
            ctrl_o.alu_src_a  = SRCA_OLDPC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_ALUWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.result_src = RES_ALUOUT;
         end
         S_BEQ: begin
            ctrl_o.branch     = 1'b1;
            ctrl_o.alu_src_a  = SRCA_REG;
            ctrl_o.alu_src_b  = SRCB_REG;
            ctrl_o.alu_op     = ALUOP_SUB;
            ctrl_o.result_src = RES_ALUOUT;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: state register and sequencing of the multicycle RV32I core, with reset forcing of all outputs.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int STATE_WIDTH = 4
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_control_fsm_if.master bus
);

   state_t state_q, state_d;
   ctrl_t  dec, ctrl;
   logic   illegal_d;

   always_ff @(posedge clk)
      state_q <= !reset ? S_FETCH : state_d;

   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      illegal_d = 1'b1;
            endcase
         end
         S_MEMADR:  state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:     state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   control_output_decoder u_dec (
      .state_i (state_q),
      .ctrl_o  (dec)
   );

   // Holding reset low masks every enable and selector so no write leaks out mid-instruction.
   assign ctrl = reset ? dec : '0;

   assign bus.pc_write   = ctrl.pc_update | (ctrl.branch & bus.zero);
   assign bus.illegal_op = reset & illegal_d;
   assign bus.adr_src    = ctrl.adr_src;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.result_src = ctrl.result_src;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.state_dbg  = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed per-cycle checks of state, enables and selectors across all instruction classes.
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   multicycle_control_fsm_if #(.STATE_WIDTH(4)) bus ();

   multicycle_control_fsm #(.STATE_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // en = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op}
   // sel = {result_src, alu_src_a, alu_src_b, alu_op}
   localparam logic [5:0] E_NONE  = 6'b000000;
   localparam logic [5:0] E_FETCH = 6'b100100;
   localparam logic [5:0] E_PC    = 6'b100000;
   localparam logic [5:0] E_ADR   = 6'b010000;
   localparam logic [5:0] E_MEMW  = 6'b011000;
   localparam logic [5:0] E_REGW  = 6'b000010;
   localparam logic [5:0] E_ILL   = 6'b000001;

   localparam logic [7:0] X_ZERO  = 8'b00_00_00_00;
   localparam logic [7:0] X_FETCH = 8'b10_00_10_00;
   localparam logic [7:0] X_DEC   = 8'b00_01_01_00;
   localparam logic [7:0] X_MADR  = 8'b00_10_01_00;
   localparam logic [7:0] X_MEMWB = 8'b01_00_00_00;
   localparam logic [7:0] X_EXECR = 8'b00_10_00_10;
   localparam logic [7:0] X_EXECI = 8'b00_10_01_10;
   localparam logic [7:0] X_JAL   = 8'b00_01_10_00;
   localparam logic [7:0] X_BEQ   = 8'b00_10_00_01;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [3:0] st, input logic [5:0] en, input logic [7:0] sel);
      logic [5:0] en_o;
      logic [7:0] sel_o;
      #1;
      en_o  = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write, bus.illegal_op};
      sel_o = {bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
      checks++;
      assert (bus.state_dbg === st) else begin
         errors++;
         $error("FAIL %s state: got %h expected %h", tag, bus.state_dbg, st);
      end
      checks++;
      assert (en_o === en) else begin
         errors++;
         $error("FAIL %s enables: got %b expected %b", tag, en_o, en);
      end
      checks++;
      assert (sel_o === sel) else begin
         errors++;
         $error("FAIL %s selectors: got %b expected %b", tag, sel_o, sel);
      end
   endtask

   initial begin
      reset   = 1'b0;
      bus.op   = 7'b0110011;
      bus.zero = 1'b0;
      tick(); chk("rst0", 4'd0, E_NONE, X_ZERO);
      tick(); chk("rst1", 4'd0, E_NONE, X_ZERO);
      tick(); chk("rst2", 4'd0, E_NONE, X_ZERO);
      reset = 1'b1;
      chk("r_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("r_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("r_execr", 4'd6, E_NONE, X_EXECR);
      tick(); chk("r_aluwb", 4'd9, E_REGW, X_ZERO);
      tick(); bus.op = 7'b0000011;
      chk("lw_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("lw_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("lw_memadr", 4'd2, E_NONE, X_MADR);
      tick(); chk("lw_memread", 4'd3, E_ADR, X_ZERO);
      tick(); chk("lw_memwb", 4'd4, E_REGW, X_MEMWB);
      tick(); bus.op = 7'b0100011;
      chk("sw_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("sw_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("sw_memadr", 4'd2, E_NONE, X_MADR);
      tick(); chk("sw_memwrite", 4'd5, E_MEMW, X_ZERO);
      tick(); bus.op = 7'b1100011; bus.zero = 1'b1;
      chk("beq1_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("beq1_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("beq1_taken", 4'd10, E_PC, X_BEQ);
      tick(); bus.zero = 1'b0;
      chk("beq0_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("beq0_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("beq0_nottaken", 4'd10, E_NONE, X_BEQ);
      tick(); bus.op = 7'b1101111; bus.zero = 1'b1;
      chk("jal_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("jal_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("jal_jal", 4'd8, E_PC, X_JAL);
      tick(); chk("jal_aluwb", 4'd9, E_REGW, X_ZERO);
      tick(); bus.op = 7'b0010011; bus.zero = 1'b0;
      chk("i_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("i_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("i_execi", 4'd7, E_NONE, X_EXECI);
      tick(); chk("i_aluwb", 4'd9, E_REGW, X_ZERO);
      tick(); bus.op = 7'b1111111;
      chk("ill_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("ill_decode", 4'd1, E_ILL, X_DEC);
      tick(); bus.op = 7'b0100011;
      chk("ill_back", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("mid_decode", 4'd1, E_NONE, X_DEC);
      tick(); chk("mid_memadr", 4'd2, E_NONE, X_MADR);
      tick(); reset = 1'b0;
      chk("mid_memwrite_rst", 4'd5, E_NONE, X_ZERO);
      tick(); chk("mid_after_edge", 4'd0, E_NONE, X_ZERO);
      reset = 1'b1;
      chk("mid_fetch", 4'd0, E_FETCH, X_FETCH);
      tick(); chk("mid_decode2", 4'd1, E_NONE, X_DEC);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
